// File: rtl/tilemap_scroll_gen.sv
// tilemap_scroll_gen
// Tile-map background renderer with smooth per-pixel horizontal scrolling.
// It sits between the VGA sync generator and the colour output. Each pixel
// position (pix_x + scroll_x, pix_y) is turned into a map ROM address, then
// the returned tile id into a pixel address in one of two tile banks. The
// fetched RGB332 pixel comes out of a fixed 3-stage pipeline, so inputs at
// cycle N show up on bit_rgb / video_on_out at cycle N+3, one pixel per clock.
// A small frame-synchronous FSM moves scroll_x left or right once per
// frame_tick from the debounced button levels.
//
// Ports
//   clk           system clock
//   reset         synchronous, active-high
//   video_on      active-video qualifier aligned with pix_x/pix_y
//   pix_x, pix_y  current pixel column / row (10 bit)
//   frame_tick    one-cycle pulse per frame during vertical blanking
//   btn_right     debounced level, scroll right
//   btn_left      debounced level, scroll left
//   map_addr      map ROM address (ROM has 1-cycle read latency)
//   tile_id       map ROM data
//   tile_addr     tile bank pixel address (banks have 1-cycle read latency)
//   bank0_data    bank0 pixel data
//   bank1_data    bank1 pixel data
//   scroll_x      current scroll offset in pixels
//   bit_rgb       registered output pixel
//   video_on_out  video_on delayed to line up with bit_rgb

module tilemap_scroll_gen #(
    parameter int          TILE_LOG2    = 5,
    parameter int          MAP_ROWS     = 15,
    parameter int          MAP_COLS     = 96,
    parameter int          VIEW_COLS    = 20,
    parameter int          BANK_SPLIT   = 16,
    parameter int          SCROLL_STEP  = 2,
    parameter logic [7:0]  TRANSP_COLOR = 8'hD7,
    parameter logic [7:0]  SKY_COLOR    = 8'hE0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        video_on,
    input  logic [9:0]  pix_x,
    input  logic [9:0]  pix_y,
    input  logic        frame_tick,
    input  logic        btn_right,
    input  logic        btn_left,
    output logic [10:0] map_addr,
    input  logic [4:0]  tile_id,
    output logic [13:0] tile_addr,
    input  logic [7:0]  bank0_data,
    input  logic [7:0]  bank1_data,
    output logic [11:0] scroll_x,
    output logic [7:0]  bit_rgb,
    output logic        video_on_out
);

    // Rightmost scroll position: the last VIEW_COLS columns fill the screen.
    localparam logic [11:0] MAX_SCROLL    = 12'((MAP_COLS - VIEW_COLS) << TILE_LOG2);
    localparam logic [4:0]  BANK_SPLIT_ID = 5'(BANK_SPLIT);

    typedef enum logic [1:0] {
        IDLE,
        SCR_R,
        SCR_L
    } scroll_state_t;

    scroll_state_t state, state_next;
    logic [11:0]   scroll_next;
    logic [12:0]   scroll_up;

    // Scroll state register. scroll_x only ever changes on a frame_tick,
    // so it is constant for every pixel of a frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            scroll_x <= '0;
        end else begin
            state    <= state_next;
            scroll_x <= scroll_next;
        end
    end

    // Scroll next-state and move. The destination state depends only on the
    // button levels at the tick, so the same rule applies from every state:
    // entering or staying in SCR_R/SCR_L moves on that very tick (including
    // an immediate reversal), and release or both-pressed parks in IDLE
    // without moving. Both directions saturate instead of wrapping; the
    // upward sum is one bit wider so the compare cannot overflow.
    always_comb begin
        state_next  = state;
        scroll_next = scroll_x;
        scroll_up   = {1'b0, scroll_x} + 13'(SCROLL_STEP);
        if (frame_tick) begin
            if (btn_right && !btn_left) begin
                state_next  = SCR_R;
                scroll_next = (scroll_up > {1'b0, MAX_SCROLL}) ? MAX_SCROLL : scroll_up[11:0];
            end else if (btn_left && !btn_right) begin
                state_next  = SCR_L;
                scroll_next = (scroll_x < 12'(SCROLL_STEP)) ? 12'd0 : scroll_x - 12'(SCROLL_STEP);
            end else begin
                state_next  = IDLE;
            end
        end
    end

    // Stage 0: world coordinate and map ROM address. The map ROM is
    // column-major, hence column * MAP_ROWS + row.
    logic [11:0] wx;
    logic [11:0] map_col;
    logic [9:0]  map_row;

    always_comb begin
        wx       = {2'b00, pix_x} + scroll_x;
        map_col  = wx >> TILE_LOG2;
        map_row  = pix_y >> TILE_LOG2;
        map_addr = 11'(map_col * 12'(MAP_ROWS)) + 11'(map_row);
    end

    logic [TILE_LOG2-1:0] s1_x_off;
    logic [TILE_LOG2-1:0] s1_y_off;
    logic                 s1_von;

    // Stage 0 -> 1 registers: in-tile offsets travel alongside the map ROM
    // read so they meet tile_id in the next cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_x_off <= '0;
            s1_y_off <= '0;
            s1_von   <= 1'b0;
        end else begin
            s1_x_off <= wx[TILE_LOG2-1:0];
            s1_y_off <= pix_y[TILE_LOG2-1:0];
            s1_von   <= video_on;
        end
    end

    // Stage 1: tile id to bank pixel address. Id 0 is empty sky and needs no
    // fetch. Ids 1..BANK_SPLIT index bank0 from its start; higher ids index
    // bank1 from its start. Within a tile, {y_off, x_off} equals
    // (y_off << TILE_LOG2) + x_off.
    logic [13:0] tile_base;
    logic        bank_sel_c;
    logic        sky_c;

    always_comb begin
        tile_base  = '0;
        bank_sel_c = 1'b0;
        sky_c      = 1'b0;
        tile_addr  = '0;
        if (tile_id == 5'd0) begin
            sky_c = 1'b1;
        end else begin
            if (tile_id <= BANK_SPLIT_ID) begin
                tile_base = (14'(tile_id) - 14'd1) << (2 * TILE_LOG2);
            end else begin
                bank_sel_c = 1'b1;
                tile_base  = (14'(tile_id) - 14'(BANK_SPLIT + 1)) << (2 * TILE_LOG2);
            end
            tile_addr = tile_base + 14'({s1_y_off, s1_x_off});
        end
    end

    logic s2_bank_sel;
    logic s2_sky;
    logic s2_von;

    // Stage 1 -> 2 registers: bank select and sky flag wait for bank data.
    always_ff @(posedge clk) begin
        if (reset) begin
            s2_bank_sel <= 1'b0;
            s2_sky      <= 1'b0;
            s2_von      <= 1'b0;
        end else begin
            s2_bank_sel <= bank_sel_c;
            s2_sky      <= sky_c;
            s2_von      <= s1_von;
        end
    end

    // Stage 2: choose the bank and resolve transparency to sky colour.
    logic [7:0] pix_data;
    logic [7:0] rgb_next;

    always_comb begin
        pix_data = s2_bank_sel ? bank1_data : bank0_data;
        rgb_next = pix_data;
        if (!s2_von) begin
            rgb_next = 8'h00;
        end else if (s2_sky || (pix_data == TRANSP_COLOR)) begin
            rgb_next = SKY_COLOR;
        end
    end

    // Output registers: blanked pixels are forced to black.
    always_ff @(posedge clk) begin
        if (reset) begin
            bit_rgb      <= 8'h00;
            video_on_out <= 1'b0;
        end else begin
            bit_rgb      <= rgb_next;
            video_on_out <= s2_von;
        end
    end

endmodule

// File: tb/tb_tilemap_scroll_gen.sv
// tb_tilemap_scroll_gen
// Self-checking bench for tilemap_scroll_gen. The map ROM and both tile banks
// are modelled as 1-cycle-latency arrays filled with random content. Expected
// pixels are computed from the map/bank contents by plain arithmetic on the
// world coordinate, and expected scroll offsets by a saturating counter.

module tb_tilemap_scroll_gen;

    localparam int MAX_SCROLL = 2432;

    logic        clk;
    logic        reset;
    logic        video_on;
    logic [9:0]  pix_x;
    logic [9:0]  pix_y;
    logic        frame_tick;
    logic        btn_right;
    logic        btn_left;
    logic [10:0] map_addr;
    logic [4:0]  tile_id;
    logic [13:0] tile_addr;
    logic [7:0]  bank0_data;
    logic [7:0]  bank1_data;
    logic [11:0] scroll_x;
    logic [7:0]  bit_rgb;
    logic        video_on_out;

    logic [4:0]  map_rom   [0:2047];
    logic [7:0]  bank0_rom [0:16383];
    logic [7:0]  bank1_rom [0:16383];

    int n_cmp;
    int n_fail;
    int model_sx;

    int exp_rgb[$];
    int exp_von[$];

    tilemap_scroll_gen dut (
        .clk          (clk),
        .reset        (reset),
        .video_on     (video_on),
        .pix_x        (pix_x),
        .pix_y        (pix_y),
        .frame_tick   (frame_tick),
        .btn_right    (btn_right),
        .btn_left     (btn_left),
        .map_addr     (map_addr),
        .tile_id      (tile_id),
        .tile_addr    (tile_addr),
        .bank0_data   (bank0_data),
        .bank1_data   (bank1_data),
        .scroll_x     (scroll_x),
        .bit_rgb      (bit_rgb),
        .video_on_out (video_on_out)
    );

    // Free-running 100 MHz clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous ROM models with one cycle of read latency.
    always @(posedge clk) begin
        tile_id    <= map_rom[map_addr];
        bank0_data <= bank0_rom[tile_addr];
        bank1_data <= bank1_rom[tile_addr];
    end

    // Reference pixel: look up the tile under the world coordinate and
    // apply the sky / transparency / blanking rules.
    function automatic int model_pixel(int x, int y, int von, int sx);
        int wx;
        int tid;
        int off;
        int d;
        if (von == 0) return 0;
        wx  = x + sx;
        tid = int'(map_rom[(wx / 32) * 15 + (y / 32)]);
        if (tid == 0) return 8'hE0;
        off = (y % 32) * 32 + (wx % 32);
        if (tid <= 16) d = int'(bank0_rom[(tid - 1) * 1024 + off]);
        else           d = int'(bank1_rom[(tid - 17) * 1024 + off]);
        return (d == 8'hD7) ? 8'hE0 : d;
    endfunction

    // Reference scroll offset after one frame_tick.
    function automatic int model_scroll(int sx, bit r, bit l);
        if (r && !l) return (sx + 2 > MAX_SCROLL) ? MAX_SCROLL : sx + 2;
        if (l && !r) return (sx < 2) ? 0 : sx - 2;
        return sx;
    endfunction

    task automatic drive_pix(int x, int y, bit von);
        pix_x    = 10'(x);
        pix_y    = 10'(y);
        video_on = von;
    endtask

    // One frame_tick pulse; returns at the negedge after the tick edge.
    task automatic do_tick(bit r, bit l);
        @(negedge clk);
        btn_right  = r;
        btn_left   = l;
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        model_sx = 0;
        n_cmp++;
        if (scroll_x !== 12'd0) begin
            n_fail++;
            $display("[TB] FAIL reset_scroll: got %0d expected 0", scroll_x);
        end
        n_cmp++;
        if (bit_rgb !== 8'h00) begin
            n_fail++;
            $display("[TB] FAIL reset_rgb: got %0h expected 0", bit_rgb);
        end
        n_cmp++;
        if (video_on_out !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL reset_von: got %0b expected 0", video_on_out);
        end
    endtask

    task automatic test_directed_pixel;
        map_rom[17]     = 5'd3;
        bank0_rom[2248] = 8'h1C;
        @(negedge clk);
        drive_pix(40, 70, 1'b1);
        #1;
        n_cmp++;
        if (map_addr !== 11'd17) begin
            n_fail++;
            $display("[TB] FAIL dir_map_addr: got %0d expected 17", map_addr);
        end
        @(negedge clk);
        drive_pix(0, 0, 1'b0);
        n_cmp++;
        if (tile_addr !== 14'd2248) begin
            n_fail++;
            $display("[TB] FAIL dir_tile_addr: got %0d expected 2248", tile_addr);
        end
        @(negedge clk);
        n_cmp++;
        if (bit_rgb !== 8'h00) begin
            n_fail++;
            $display("[TB] FAIL dir_rgb_early: got %0h expected 0", bit_rgb);
        end
        @(negedge clk);
        n_cmp++;
        if (bit_rgb !== 8'h1C || video_on_out !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL dir_rgb: got %0h/%0b expected 1c/1", bit_rgb, video_on_out);
        end
    endtask

    task automatic test_tile_cases;
        int cx[4]  = '{100, 300, 330, 40};
        int cy[4]  = '{200, 150, 40, 70};
        int cv[4]  = '{1, 1, 1, 0};
        int ca[4]  = '{0, 3788, 3338, 2248};
        int ce[4]  = '{8'hE0, 8'hE0, 8'h03, 8'h00};
        map_rom[51]     = 5'd0;
        map_rom[139]    = 5'd20;
        bank1_rom[3788] = 8'hD7;
        map_rom[151]    = 5'd20;
        bank1_rom[3338] = 8'h03;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            drive_pix(cx[i], cy[i], cv[i] != 0);
            @(negedge clk);
            drive_pix(0, 0, 1'b0);
            n_cmp++;
            if (tile_addr !== 14'(ca[i])) begin
                n_fail++;
                $display("[TB] FAIL case%0d_tile_addr: got %0d expected %0d", i, tile_addr, ca[i]);
            end
            repeat (2) @(negedge clk);
            n_cmp++;
            if (bit_rgb !== 8'(ce[i]) || video_on_out !== 1'(cv[i])) begin
                n_fail++;
                $display("[TB] FAIL case%0d_rgb: got %0h/%0b expected %0h/%0d",
                         i, bit_rgb, video_on_out, ce[i], cv[i]);
            end
        end
    endtask

    task automatic test_scroll_right10;
        for (int i = 0; i < 10; i++) begin
            do_tick(1'b1, 1'b0);
            model_sx = model_scroll(model_sx, 1'b1, 1'b0);
            n_cmp++;
            if (scroll_x !== 12'(model_sx)) begin
                n_fail++;
                $display("[TB] FAIL right10_tick%0d: got %0d expected %0d", i, scroll_x, model_sx);
            end
            btn_right = 1'($urandom_range(0, 1));
            btn_left  = 1'($urandom_range(0, 1));
            repeat (2) @(negedge clk);
            n_cmp++;
            if (scroll_x !== 12'(model_sx)) begin
                n_fail++;
                $display("[TB] FAIL right10_between%0d: got %0d expected %0d", i, scroll_x, model_sx);
            end
        end
        n_cmp++;
        if (scroll_x !== 12'd20) begin
            n_fail++;
            $display("[TB] FAIL right10_total: got %0d expected 20", scroll_x);
        end
        drive_pix(12, 0, 1'b0);
        #1;
        n_cmp++;
        if (map_addr !== 11'd15) begin
            n_fail++;
            $display("[TB] FAIL right10_map_col: got %0d expected 15", map_addr);
        end
        do_tick(1'b0, 1'b0);
        n_cmp++;
        if (scroll_x !== 12'd20) begin
            n_fail++;
            $display("[TB] FAIL release_no_move: got %0d expected 20", scroll_x);
        end
    endtask

    task automatic test_saturate_high;
        while (model_sx < 2430) begin
            do_tick(1'b1, 1'b0);
            model_sx = model_scroll(model_sx, 1'b1, 1'b0);
            n_cmp++;
            if (scroll_x !== 12'(model_sx)) begin
                n_fail++;
                $display("[TB] FAIL climb: got %0d expected %0d", scroll_x, model_sx);
            end
        end
        for (int i = 0; i < 2; i++) begin
            do_tick(1'b1, 1'b0);
            model_sx = model_scroll(model_sx, 1'b1, 1'b0);
            n_cmp++;
            if (scroll_x !== 12'd2432) begin
                n_fail++;
                $display("[TB] FAIL sat_high%0d: got %0d expected 2432", i, scroll_x);
            end
        end
    endtask

    task automatic test_reversal;
        while (model_sx > 98) begin
            do_tick(1'b0, 1'b1);
            model_sx = model_scroll(model_sx, 1'b0, 1'b1);
            n_cmp++;
            if (scroll_x !== 12'(model_sx)) begin
                n_fail++;
                $display("[TB] FAIL descend: got %0d expected %0d", scroll_x, model_sx);
            end
        end
        do_tick(1'b1, 1'b0);
        model_sx = model_scroll(model_sx, 1'b1, 1'b0);
        n_cmp++;
        if (scroll_x !== 12'd100) begin
            n_fail++;
            $display("[TB] FAIL rev_right: got %0d expected 100", scroll_x);
        end
        do_tick(1'b0, 1'b1);
        model_sx = model_scroll(model_sx, 1'b0, 1'b1);
        n_cmp++;
        if (scroll_x !== 12'd98) begin
            n_fail++;
            $display("[TB] FAIL rev_left: got %0d expected 98", scroll_x);
        end
        for (int i = 0; i < 5; i++) begin
            do_tick(1'b1, 1'b1);
            n_cmp++;
            if (scroll_x !== 12'd98) begin
                n_fail++;
                $display("[TB] FAIL both_pressed%0d: got %0d expected 98", i, scroll_x);
            end
        end
    endtask

    task automatic test_saturate_low;
        while (model_sx > 0) begin
            do_tick(1'b0, 1'b1);
            model_sx = model_scroll(model_sx, 1'b0, 1'b1);
        end
        n_cmp++;
        if (scroll_x !== 12'd0) begin
            n_fail++;
            $display("[TB] FAIL reach_zero: got %0d expected 0", scroll_x);
        end
        for (int i = 0; i < 2; i++) begin
            do_tick(1'b0, 1'b1);
            n_cmp++;
            if (scroll_x !== 12'd0) begin
                n_fail++;
                $display("[TB] FAIL sat_low%0d: got %0d expected 0", i, scroll_x);
            end
        end
    endtask

    task automatic test_random_scroll;
        bit r;
        bit l;
        for (int i = 0; i < 300; i++) begin
            r = ($urandom_range(0, 3) != 0);
            l = ($urandom_range(0, 3) == 0);
            do_tick(r, l);
            model_sx = model_scroll(model_sx, r, l);
            n_cmp++;
            if (scroll_x !== 12'(model_sx)) begin
                n_fail++;
                $display("[TB] FAIL rand_scroll%0d: got %0d expected %0d", i, scroll_x, model_sx);
            end
        end
    endtask

    task automatic test_random_pixels;
        int x;
        int y;
        int v;
        exp_rgb.delete();
        exp_von.delete();
        drive_pix(0, 0, 1'b0);
        repeat (3) @(negedge clk);
        for (int i = 0; i < 403; i++) begin
            @(negedge clk);
            if (exp_rgb.size() == 3) begin
                int er;
                int ev;
                er = exp_rgb.pop_front();
                ev = exp_von.pop_front();
                n_cmp++;
                if (bit_rgb !== 8'(er) || video_on_out !== 1'(ev)) begin
                    n_fail++;
                    $display("[TB] FAIL rand_pix%0d: got %0h/%0b expected %0h/%0d",
                             i, bit_rgb, video_on_out, er, ev);
                end
            end
            if (i < 400) begin
                x = $urandom_range(0, 639);
                y = $urandom_range(0, 479);
                v = ($urandom_range(0, 7) != 0) ? 1 : 0;
            end else begin
                x = 0;
                y = 0;
                v = 0;
            end
            drive_pix(x, y, v != 0);
            exp_rgb.push_back(model_pixel(x, y, v, model_sx));
            exp_von.push_back(v);
        end
    endtask

    task automatic test_reset_mid_line;
        int x;
        int y;
        while (model_sx != 500) begin
            if (model_sx < 500) begin
                do_tick(1'b1, 1'b0);
                model_sx = model_scroll(model_sx, 1'b1, 1'b0);
            end else begin
                do_tick(1'b0, 1'b1);
                model_sx = model_scroll(model_sx, 1'b0, 1'b1);
            end
        end
        n_cmp++;
        if (scroll_x !== 12'd500) begin
            n_fail++;
            $display("[TB] FAIL pre_reset_scroll: got %0d expected 500", scroll_x);
        end
        exp_rgb.delete();
        exp_von.delete();
        drive_pix(0, 0, 1'b0);
        repeat (3) @(negedge clk);
        for (int i = 0; i < 43; i++) begin
            @(negedge clk);
            if (exp_rgb.size() == 3) begin
                int er;
                int ev;
                er = exp_rgb.pop_front();
                ev = exp_von.pop_front();
                n_cmp++;
                if (bit_rgb !== 8'(er) || video_on_out !== 1'(ev)) begin
                    n_fail++;
                    $display("[TB] FAIL rst_pix%0d: got %0h/%0b expected %0h/%0d",
                             i, bit_rgb, video_on_out, er, ev);
                end
            end
            x = $urandom_range(0, 639);
            y = $urandom_range(0, 479);
            if (i == 20) begin
                reset = 1'b1;
                foreach (exp_rgb[j]) begin
                    exp_rgb[j] = 0;
                    exp_von[j] = 0;
                end
                drive_pix(x, y, 1'b1);
                exp_rgb.push_back(0);
                exp_von.push_back(0);
            end else begin
                if (i == 21) begin
                    reset    = 1'b0;
                    model_sx = 0;
                    n_cmp++;
                    if (scroll_x !== 12'd0) begin
                        n_fail++;
                        $display("[TB] FAIL rst_scroll: got %0d expected 0", scroll_x);
                    end
                end
                drive_pix(x, y, i < 40);
                exp_rgb.push_back(model_pixel(x, y, (i < 40) ? 1 : 0, model_sx));
                exp_von.push_back((i < 40) ? 1 : 0);
            end
        end
    endtask

    // Main sequence: fill ROMs, then run each scenario in turn.
    initial begin
        n_cmp      = 0;
        n_fail     = 0;
        model_sx   = 0;
        reset      = 1'b1;
        video_on   = 1'b0;
        pix_x      = '0;
        pix_y      = '0;
        frame_tick = 1'b0;
        btn_right  = 1'b0;
        btn_left   = 1'b0;
        for (int i = 0; i < 2048; i++) map_rom[i] = 5'($urandom_range(0, 31));
        for (int i = 0; i < 16384; i++) begin
            bank0_rom[i] = ($urandom_range(0, 7) == 0) ? 8'hD7 : 8'($urandom_range(0, 255));
            bank1_rom[i] = ($urandom_range(0, 7) == 0) ? 8'hD7 : 8'($urandom_range(0, 255));
        end
        $display("[TB] starting tilemap_scroll_gen bench");
        test_reset();
        test_directed_pixel();
        test_tile_cases();
        test_scroll_right10();
        test_saturate_high();
        test_reversal();
        test_saturate_low();
        test_random_scroll();
        test_random_pixels();
        test_reset_mid_line();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
